btb_set_ctrl: RTL

- Storage and control stage wrapped around the BTB write-back logic. Owns the 8-set x 128-bit BTB array and one LRU bit per set.
- Update path: accepts branch-resolution updates, reads the addressed set, computes hit and LRU selection, drives the write-back logic, and commits the returned set.
- Lookup path: serves registered fetch lookups.
- Clear: runs a clear sequence after reset and after a flush request.

---
 rtl/btb_set_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/btb_set_ctrl.sv
// btb_set_ctrl: BTB set array, LRU bits, clear sequencer, update stage A and registered lookup.
module btb_set_ctrl #(
  parameter int NUM_SETS = 8,
  parameter int SET_W    = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             upd_valid_i,
  output logic             upd_ready_o,
  input  logic [31:0]      upd_pc_i,
  input  logic [31:0]      upd_target_i,
  input  logic             upd_mispredicted_i,
  input  logic             lkp_valid_i,
  input  logic [31:0]      lkp_pc_i,
  output logic             lkp_hit_o,
  output logic [31:0]      lkp_target_o,
  output logic             lkp_taken_o,
  output logic [SET_W-1:0] wl_old_set_o,
  output logic [26:0]      wl_new_tag_o,
  output logic [31:0]      wl_new_target_o,
  output logic             wl_mispredicted_o,
  output logic             wl_update_branch1_o,
  output logic             wl_update_branch2_o,
  output logic             wl_lru_write_o,
  input  logic [SET_W-1:0] wl_write_set_i,
  output logic             busy_o
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nx;
  logic [2:0] clr_cnt;
  logic [SET_W-1:0] mem [NUM_SETS];
  logic [NUM_SETS-1:0] lru;
  logic a_valid, a_misp;
  logic [29:0] a_pc;
  logic [31:0] a_target;
  logic [2:0] a_idx, l_idx;
  logic [26:0] a_tag, l_tag;
  logic [SET_W-1:0] old_set, l_set;
  logic accept, hit1, hit2, slot1_touch, l_hit1, l_hit2, l_hit;
  logic pc_lsb_unused;
  assign a_idx = a_pc[2:0];
  assign a_tag = a_pc[29:3];
  assign old_set = mem[a_idx];
  assign upd_ready_o = state == RUN && !flush_i;
  assign busy_o = state == CLEAR;
  assign accept = upd_valid_i && upd_ready_o;
  assign hit1 = old_set[127] && old_set[126:100] == a_tag;
  assign hit2 = old_set[63] && old_set[62:36] == a_tag && !hit1;
  assign slot1_touch = hit1 || (!hit2 && lru[a_idx]);
  assign wl_old_set_o = a_valid ? old_set : '0;
  assign wl_new_tag_o = a_valid ? a_tag : '0;
  assign wl_new_target_o = a_valid ? a_target : '0;
  assign wl_mispredicted_o = a_valid && a_misp;
  assign wl_update_branch1_o = a_valid && hit1;
  assign wl_update_branch2_o = a_valid && hit2;
  assign wl_lru_write_o = a_valid && lru[a_idx];
  // a lookup into the set being committed sees the merged word, not the stale one
  assign l_idx = lkp_pc_i[4:2];
  assign l_tag = lkp_pc_i[31:5];
  assign l_set = (a_valid && l_idx == a_idx) ? wl_write_set_i : mem[l_idx];
  assign l_hit1 = l_set[127] && l_set[126:100] == l_tag;
  assign l_hit2 = l_set[63] && l_set[62:36] == l_tag;
  assign l_hit = lkp_valid_i && state == RUN && (l_hit1 || l_hit2);
  assign pc_lsb_unused = ^{upd_pc_i[1:0], lkp_pc_i[1:0], l_set[66:64], l_set[2:0]};
  always_comb begin
    state_nx = state;
    if (flush_i) state_nx = CLEAR;
    else if (state == CLEAR && clr_cnt == 3'd7) state_nx = RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      clr_cnt <= '0;
      a_valid <= 1'b0;
      lkp_hit_o <= 1'b0;
      lkp_target_o <= '0;
      lkp_taken_o <= 1'b0;
    end else begin
      state <= state_nx;
      clr_cnt <= (flush_i || state != CLEAR) ? 3'd0 : clr_cnt + 3'd1;
      a_valid <= accept;
      lkp_hit_o <= l_hit;
      lkp_target_o <= !l_hit ? 32'd0 : l_hit1 ? l_set[99:68] : l_set[35:4];
      lkp_taken_o <= l_hit && (l_hit1 ? l_set[67] : l_set[3]);
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      a_pc <= upd_pc_i[31:2];
      a_target <= upd_target_i;
      a_misp <= upd_mispredicted_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
        lru[clr_cnt] <= 1'b1;
      end else if (a_valid && !flush_i) begin
        mem[a_idx] <= wl_write_set_i;
        lru[a_idx] <= !slot1_touch;
      end
    end
  end
endmodule
